// File: rtl/fir_coeff_ctrl_pkg.sv
// Shared constants and FSM encoding for the FIR coefficient controller.
// Coefficients are double-buffered: a shadow bank is written, then committed to the active bank.
package fir_coeff_ctrl_pkg;

    localparam int unsigned Div        = 40;  // 12 MHz cycles per 300 kHz sample
    localparam int unsigned NumTap     = 12;
    localparam int unsigned CoeffW     = 16;
    localparam int unsigned NumSeg     = 4;
    localparam int unsigned TapsPerSeg = 3;

    typedef enum logic [0:0] {
        StIdle    = 1'b0,
        StPending = 1'b1
    } state_e;

endpackage

// File: rtl/fir_coeff_ctrl_if.sv
// Coefficient write / commit handshake and coefficient outputs of fir_coeff_ctrl.
// The master side drives writes and commits; the slave side is the controller.
interface fir_coeff_ctrl_if
    import fir_coeff_ctrl_pkg::*;
#(
    parameter int unsigned NUM_TAP = NumTap
);

    logic                      iCoeffWrValid;
    logic                      oCoeffWrReady;
    logic [3:0]                iCoeffWrAddr;
    logic [CoeffW-1:0]         iCoeffWrData;
    logic                      iCommit;
    logic                      oCommitPending;
    logic                      oCommitDone;
    logic                      oAddrErr;
    logic                      oEnSample_300k;
    logic [CoeffW*NUM_TAP-1:0] oCoeffBus;
    logic [NumSeg-1:0]         oEnMul;

    modport master (
        output iCoeffWrValid, iCoeffWrAddr, iCoeffWrData, iCommit,
        input  oCoeffWrReady, oCommitPending, oCommitDone, oAddrErr,
        input  oEnSample_300k, oCoeffBus, oEnMul
    );

    modport slave (
        input  iCoeffWrValid, iCoeffWrAddr, iCoeffWrData, iCommit,
        output oCoeffWrReady, oCommitPending, oCommitDone, oAddrErr,
        output oEnSample_300k, oCoeffBus, oEnMul
    );

endinterface

// File: rtl/fir_sample_tick.sv
// Free-running divider: one-cycle tick when the counter reaches DIV-1, then wraps to 0.
// The tick is forced low while reset is held.
module fir_sample_tick
    import fir_coeff_ctrl_pkg::*;
#(
    parameter int unsigned DIV = Div
) (
    input  logic iClk_12M,
    input  logic iRst,
    output logic oTick
);

    localparam int unsigned CntW = (DIV > 1) ? $clog2(DIV) : 1;

    logic [CntW-1:0] rCnt;
    logic            cnt_last;

    assign cnt_last = (rCnt == CntW'(DIV - 1));

    always_ff @(posedge iClk_12M) begin
        if (iRst) begin
            rCnt <= '0;
        end else if (cnt_last) begin
            rCnt <= '0;
        end else begin
            rCnt <= rCnt + CntW'(1);
        end
    end

    assign oTick = cnt_last && !iRst;

endmodule

// File: rtl/fir_coeff_ctrl.sv
// Double-buffered FIR coefficient bank: writes land in the shadow bank, a commit copies it
// into the active bank on the next sample strobe so the FIR never sees a half-updated set.
module fir_coeff_ctrl
    import fir_coeff_ctrl_pkg::*;
#(
    parameter int unsigned DIV     = Div,
    parameter int unsigned NUM_TAP = NumTap
) (
    input  logic            iClk_12M,
    input  logic            iRst,
    fir_coeff_ctrl_if.slave bus
);

    localparam int unsigned BankW = CoeffW * NUM_TAP;

    state_e            state_q, state_d;
    logic [BankW-1:0]  shadow_q, shadow_d;
    logic [BankW-1:0]  active_q;
    logic [NumSeg-1:0] en_mul_q, en_mul_d;
    logic              done_q;
    logic              err_q;
    logic              strobe;
    logic              ready;
    logic              wr_fire;
    logic              wr_in_range;
    logic              swap;

    fir_sample_tick #(
        .DIV (DIV)
    ) u_tick (
        .iClk_12M (iClk_12M),
        .iRst     (iRst),
        .oTick    (strobe)
    );

    assign ready       = (state_q == StIdle) && !iRst;
    assign wr_fire     = bus.iCoeffWrValid && ready;
    assign wr_in_range = (32'(bus.iCoeffWrAddr) < NUM_TAP);

    // A commit raised on a strobe cycle waits for the following strobe, since IDLE never swaps.
    always_comb begin
        state_d = state_q;
        swap    = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (bus.iCommit) begin
                    state_d = StPending;
                end
            end
            StPending: begin
                if (strobe) begin
                    swap    = 1'b1;
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        shadow_d = shadow_q;
        for (int unsigned k = 0; k < NUM_TAP; k++) begin
            if (wr_fire && (32'(bus.iCoeffWrAddr) == k)) begin
                shadow_d[k*CoeffW +: CoeffW] = bus.iCoeffWrData;
            end
        end
    end

    // Multiplier enables follow the bank being committed, so they switch together with it.
    always_comb begin
        en_mul_d = '0;
        for (int unsigned s = 0; s < NumSeg; s++) begin
            for (int unsigned t = 0; t < TapsPerSeg; t++) begin
                if ((s * TapsPerSeg + t) < NUM_TAP) begin
                    if (shadow_q[(s*TapsPerSeg+t)*CoeffW +: CoeffW] != '0) begin
                        en_mul_d[s] = 1'b1;
                    end
                end
            end
        end
    end

    always_ff @(posedge iClk_12M) begin
        if (iRst) begin
            state_q  <= StIdle;
            shadow_q <= '0;
            active_q <= '0;
            en_mul_q <= '0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            shadow_q <= shadow_d;
            if (swap) begin
                active_q <= shadow_q;
                en_mul_q <= en_mul_d;
            end
            done_q <= swap;
            err_q  <= wr_fire && !wr_in_range;
        end
    end

    assign bus.oCoeffWrReady  = ready;
    assign bus.oCommitPending = (state_q == StPending);
    assign bus.oCommitDone    = done_q;
    assign bus.oAddrErr       = err_q;
    assign bus.oEnSample_300k = strobe;
    assign bus.oCoeffBus      = active_q;
    assign bus.oEnMul         = en_mul_q;

endmodule

// File: tb/tb_fir_coeff_ctrl.sv
// Self-checking bench for fir_coeff_ctrl: directed scenarios plus randomized traffic,
// compared every cycle against a behavioural model of the coefficient banks.
module tb_fir_coeff_ctrl;

    localparam int unsigned DIV_P = 40;
    localparam int unsigned NT    = 12;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    fir_coeff_ctrl_if #(.NUM_TAP(NT)) bus_if ();

    fir_coeff_ctrl #(
        .DIV     (DIV_P),
        .NUM_TAP (NT)
    ) dut (
        .iClk_12M (clk),
        .iRst     (rst),
        .bus      (bus_if)
    );

    int checks = 0;
    int errors = 0;

    // Behavioural model: cycle count since reset release, pending flag, two banks.
    int unsigned cyc = 0;
    bit          model_ok = 1'b0;
    bit          pend_m = 1'b0;
    bit          done_m = 1'b0;
    bit          err_m = 1'b0;
    logic [15:0] sh_m [NT];
    logic [15:0] ac_m [NT];
    logic [191:0] lit;

    task automatic check(input string name, input logic [191:0] act, input logic [191:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic bit strobe_m();
        return !rst && ((cyc % DIV_P) == DIV_P - 1);
    endfunction

    function automatic logic [191:0] bus_m();
        logic [191:0] v = '0;
        for (int k = 0; k < NT; k++) v[16*k +: 16] = ac_m[k];
        return v;
    endfunction

    function automatic logic [3:0] enmul_m();
        logic [3:0] e = '0;
        for (int k = 0; k < NT; k++) if (ac_m[k] != 16'h0) e[k/3] = 1'b1;
        return e;
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            model_ok <= 1'b1;
            cyc      <= 0;
            pend_m   <= 1'b0;
            done_m   <= 1'b0;
            err_m    <= 1'b0;
            for (int k = 0; k < NT; k++) begin
                sh_m[k] <= 16'h0;
                ac_m[k] <= 16'h0;
            end
        end else begin
            cyc    <= cyc + 1;
            done_m <= pend_m && strobe_m();
            err_m  <= bus_if.iCoeffWrValid && !pend_m && (bus_if.iCoeffWrAddr >= NT);
            if (pend_m && strobe_m()) begin
                for (int k = 0; k < NT; k++) ac_m[k] <= sh_m[k];
                pend_m <= 1'b0;
            end else if (!pend_m && bus_if.iCommit) begin
                pend_m <= 1'b1;
            end
            if (bus_if.iCoeffWrValid && !pend_m && (bus_if.iCoeffWrAddr < NT))
                sh_m[bus_if.iCoeffWrAddr] <= bus_if.iCoeffWrData;
        end
    end

    always @(negedge clk) begin
        if (model_ok) begin
            check("strobe",  bus_if.oEnSample_300k, strobe_m());
            check("ready",   bus_if.oCoeffWrReady, !rst && !pend_m);
            check("pending", bus_if.oCommitPending, pend_m);
            check("done",    bus_if.oCommitDone, done_m);
            check("addrerr", bus_if.oAddrErr, err_m);
            check("coeffbus", bus_if.oCoeffBus, bus_m());
            check("enmul",   bus_if.oEnMul, enmul_m());
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        bus_if.iCoeffWrValid = 1'b0;
        bus_if.iCommit       = 1'b0;
        repeat (n) step();
    endtask

    initial begin
        int n;
        bus_if.iCoeffWrValid = 1'b0;
        bus_if.iCoeffWrAddr  = '0;
        bus_if.iCoeffWrData  = '0;
        bus_if.iCommit       = 1'b0;
        rst = 1'b1;
        repeat (3) step();
        #1;
        check("rst_ready", bus_if.oCoeffWrReady, 1'b0);
        check("rst_bus", bus_if.oCoeffBus, 192'h0);
        rst = 1'b0;  // cycle 0

        // Load taps 0..11 with 1..12, commit at cycle 50, swap at the cycle-79 edge.
        for (int k = 0; k < NT; k++) begin
            bus_if.iCoeffWrValid = 1'b1;
            bus_if.iCoeffWrAddr  = 4'(k);
            bus_if.iCoeffWrData  = 16'(k + 1);
            step();
        end
        idle(26);  // cycle 38
        #1 check("no_strobe_38", bus_if.oEnSample_300k, 1'b0);
        step();
        #1 check("strobe_39", bus_if.oEnSample_300k, 1'b1);
        idle(11);  // cycle 50
        bus_if.iCommit = 1'b1;
        step();
        bus_if.iCommit = 1'b0;
        #1 check("pending_51", bus_if.oCommitPending, 1'b1);
        idle(28);  // cycle 79
        #1 check("bus_old_79", bus_if.oCoeffBus, 192'h0);
        step();    // cycle 80
        lit = '0;
        for (int k = 0; k < NT; k++) lit[16*k +: 16] = 16'(k + 1);
        #1;
        check("bus_new_80", bus_if.oCoeffBus, lit);
        check("enmul_80", bus_if.oEnMul, 4'b1111);
        check("done_80", bus_if.oCommitDone, 1'b1);

        // Write during PENDING stalls until the swap at the cycle-119 edge.
        idle(5);   // cycle 85
        bus_if.iCommit = 1'b1;
        step();
        bus_if.iCommit = 1'b0;
        idle(4);   // cycle 90
        bus_if.iCoeffWrValid = 1'b1;
        bus_if.iCoeffWrAddr  = 4'd3;
        bus_if.iCoeffWrData  = 16'h8000;
        #1 check("stall_ready", bus_if.oCoeffWrReady, 1'b0);
        n = 0;
        while (!bus_if.oCoeffWrReady && n < 100) begin
            step();
            n++;
        end
        check("stall_len", 32'(n), 32'd30);
        check("tap3_before", bus_if.oCoeffBus[48 +: 16], 16'h0004);
        step();
        bus_if.iCoeffWrValid = 1'b0;

        // Zero segment 2, then an out-of-range write that must only raise oAddrErr.
        for (int k = 6; k < 9; k++) begin
            bus_if.iCoeffWrValid = 1'b1;
            bus_if.iCoeffWrAddr  = 4'(k);
            bus_if.iCoeffWrData  = 16'h0;
            step();
        end
        bus_if.iCoeffWrAddr = 4'd12;
        bus_if.iCoeffWrData = 16'h1234;
        step();
        bus_if.iCoeffWrValid = 1'b0;
        #1 check("addrerr_pulse", bus_if.oAddrErr, 1'b1);
        step();
        #1 check("addrerr_once", bus_if.oAddrErr, 1'b0);
        bus_if.iCommit = 1'b1;
        step();
        bus_if.iCommit = 1'b0;
        n = 0;
        while (!bus_if.oCommitDone && n < 100) begin
            step();
            n++;
        end
        check("commit2_bound", 32'(n < 100), 32'd1);
        check("enmul_1011", bus_if.oEnMul, 4'b1011);
        check("tap3_8000", bus_if.oCoeffBus[48 +: 16], 16'h8000);
        check("tap6_zero", bus_if.oCoeffBus[96 +: 16], 16'h0);

        // Commit in a strobe cycle, then reset mid-PENDING: no swap, divider restarts.
        bus_if.iCoeffWrValid = 1'b1;
        bus_if.iCoeffWrAddr  = 4'd0;
        bus_if.iCoeffWrData  = 16'h7777;
        step();
        bus_if.iCoeffWrValid = 1'b0;
        while ((cyc % DIV_P) != DIV_P - 1) step();
        bus_if.iCommit = 1'b1;
        step();
        bus_if.iCommit = 1'b0;
        #1;
        check("strobe_commit_pend", bus_if.oCommitPending, 1'b1);
        check("strobe_commit_nodone", bus_if.oCommitDone, 1'b0);
        idle(20);
        rst = 1'b1;
        step();
        rst = 1'b0;  // cycle 0 again
        #1;
        check("abort_pend", bus_if.oCommitPending, 1'b0);
        check("abort_bus", bus_if.oCoeffBus, 192'h0);
        idle(39);
        #1 check("restart_strobe", bus_if.oEnSample_300k, 1'b1);
        step();
        #1 check("abort_nodone", bus_if.oCommitDone, 1'b0);

        // Same strobe-cycle commit without reset: swap lands one full period later.
        bus_if.iCoeffWrValid = 1'b1;
        bus_if.iCoeffWrAddr  = 4'd0;
        bus_if.iCoeffWrData  = 16'h0055;
        step();
        bus_if.iCoeffWrValid = 1'b0;
        while ((cyc % DIV_P) != DIV_P - 1) step();
        bus_if.iCommit = 1'b1;
        step();
        bus_if.iCommit = 1'b0;
        idle(DIV_P - 1);
        #1 check("late_swap_wait", bus_if.oCoeffBus[15:0], 16'h0);
        step();
        #1;
        check("late_swap_done", bus_if.oCommitDone, 1'b1);
        check("late_swap_tap0", bus_if.oCoeffBus[15:0], 16'h0055);

        // Randomized traffic against the model.
        for (int i = 0; i < 4000; i++) begin
            bus_if.iCoeffWrValid = 1'($urandom_range(0, 1));
            bus_if.iCoeffWrAddr  = 4'($urandom_range(0, 15));
            bus_if.iCoeffWrData  = ($urandom_range(0, 2) == 0) ? 16'h0 : 16'($urandom);
            bus_if.iCommit       = ($urandom_range(0, 15) == 0);
            rst                  = ($urandom_range(0, 399) == 0);
            step();
        end
        rst = 1'b0;
        idle(DIV_P * 2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/fir_coeff_ctrl.md
FIR_COEFF_CTRL -- requirements
Module: fir_coeff_ctrl

Interface
REQ-001 Parameter DIV, default 40, meaning: 12 MHz clock cycles per 300 kHz sample period.
REQ-002 Parameter NUM_TAP, default 12, meaning: coefficients held (4 segments x 3 taps); tap k belongs to segment k/3.
REQ-003 Port iClk_12M  input  1  meaning: single 12 MHz clock; one clock domain, all logic on its rising edge.
REQ-004 Port iRst  input  1  meaning: reset, synchronous, active-high.
REQ-005 Port iCoeffWrValid  input  1  meaning: coefficient write request.
REQ-006 Port oCoeffWrReady  output  1  meaning: write accepted when iCoeffWrValid and oCoeffWrReady are both high.
REQ-007 Port iCoeffWrAddr  input  4  meaning: tap index 0..NUM_TAP-1.
REQ-008 Port iCoeffWrData  input  16  meaning: signed coefficient value.
REQ-009 Port iCommit  input  1  meaning: single-cycle request to move the shadow bank into the active bank.
REQ-010 Port oCommitPending  output  1  meaning: a commit is waiting for the next sample strobe.
REQ-011 Port oCommitDone  output  1  meaning: one-cycle pulse, high in the cycle after the bank swap.
REQ-012 Port oAddrErr  output  1  meaning: one-cycle pulse, high in the cycle after an accepted write whose address is >= NUM_TAP.
REQ-013 Port oEnSample_300k  output  1  meaning: sample strobe to the FIR segments.
REQ-014 Port oCoeffBus  output  16*NUM_TAP  meaning: active coefficients; tap k occupies bits [16k+15:16k].
REQ-015 Port oEnMul  output  4  meaning: oEnMul[s] is high iff any active coefficient of segment s is nonzero.

Function
REQ-016 Divider counter rCnt shall count 0..DIV-1 and wrap to 0; oEnSample_300k shall be high exactly when rCnt==DIV-1, so it is one cycle wide every DIV cycles.
REQ-017 First oEnSample_300k shall occur in cycle DIV-1, counting the first cycle with iRst low as cycle 0.
REQ-018 FSM states: IDLE, PENDING; oCommitPending is high iff the state is PENDING.
REQ-019 IDLE: oCoeffWrReady=1; iCommit=1 moves the FSM to PENDING.
REQ-020 PENDING: oCoeffWrReady=0, keeping the shadow bank frozen; iCommit is ignored.
REQ-021 PENDING with oEnSample_300k=1: at that clock edge, all NUM_TAP active registers shall load the shadow values, oEnMul shall load values computed from the shadow bank, and the FSM returns to IDLE; oCommitDone pulses in the following cycle.
REQ-022 Swap latency: the new coefficients are visible on oCoeffBus from the cycle after the strobe and stay stable for the whole next sample period; FIR stages register with the old values on the strobe edge.
REQ-023 A write accepted in the same cycle as iCommit (IDLE) shall be included in the committed bank.
REQ-024 iCommit in IDLE during a strobe cycle shall enter PENDING; the swap shall occur at the next strobe, not the current one.
REQ-025 Accepted write with address < NUM_TAP shall update only that shadow entry on that edge.
REQ-026 Accepted write with address >= NUM_TAP shall change no shadow entry and shall raise oAddrErr.
REQ-027 Coefficients are stored bit-exact and signed; there is no saturation or scaling. oEnMul is a per-segment OR-reduction over 48 bits.

Reset
REQ-028 While iRst=1:
- rCnt=0; state=IDLE.
- All shadow and active entries = 0.
- oCoeffBus=0; oEnMul=4'b0000; oEnSample_300k=0.
- oCommitPending=0; oCommitDone=0; oAddrErr=0.
- oCoeffWrReady=0.
REQ-029 iRst asserted while PENDING shall abort the commit with no swap; the cleared state takes effect at that edge.

Structure
REQ-030 A shared package shall hold DIV, NUM_TAP, the coefficient width (16), the segment count (4), taps per segment (3) and the FSM state encoding.
REQ-031 One sub-module, fir_sample_tick (parameterised divider producing oEnSample_300k), shall be instantiated; the bank and FSM logic stay in fir_coeff_ctrl.

Verification
REQ-032 Release reset and run 200 cycles -> oEnSample_300k is high at cycles 39, 79, 119, 159, 199 only; all outputs are zero before the first strobe.
REQ-033 Write taps 0..11 = 1..12, assert iCommit at cycle 50 -> oCommitPending goes high; at the cycle-79 edge oCoeffBus takes values 1..12; oCommitDone=1 in cycle 80; oEnMul=4'b1111.
REQ-034 Write tap 3 = 16'h8000 while PENDING -> oCoeffWrReady=0, the write stalls until after the swap, then completes; the shadow bank is not changed during PENDING.
REQ-035 Commit a bank in which taps 6..8 = 0 and all others are nonzero; separately, write address 12 -> oEnMul=4'b1011; oAddrErr pulses once; the shadow bank is unchanged by the address-12 write.
REQ-036 Assert iCommit in a strobe cycle, then assert iRst for 1 cycle mid-PENDING -> the swap happens at the next strobe only in the no-reset run; in the reset run there is no swap, oCoeffBus=0 and the divider restarts.
